// File: rtl/siso_shift_ctrl.sv
// Serializes a parallel word MSB-first into an external DEPTH-flop SISO chain,
// reassembles the returned stream and flags any difference from the word sent.
module siso_shift_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             abort,
   output logic             sio_en,
   output logic             sio_din,
   input  logic             sio_dout,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             mismatch,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + DEPTH);
   localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] FLUSH_LAST = CW'(WIDTH + DEPTH - 1);
   localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_hold_q, rx_hold_d;
   logic             mm_hold_q, mm_hold_d;
   logic             active, last;

   assign active = (state_q == SHIFT) || (state_q == FLUSH);
   assign last   = (state_q == FLUSH) && (cnt_q == FLUSH_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (in_valid) state_d = SHIFT;
         SHIFT: if (abort) state_d = IDLE;
                else if (cnt_q == SHIFT_LAST) state_d = FLUSH;
         FLUSH: if (abort) state_d = IDLE;
                else if (cnt_q == FLUSH_LAST) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: the counter is cleared on the final enabled cycle so it never wraps.
   always_comb begin
      cnt_d      = cnt_q;
      tx_d       = tx_q;
      sh_d       = sh_q;
      rx_shift_d = rx_shift_q;
      rx_hold_d  = rx_hold_q;
      mm_hold_d  = mm_hold_q;
      if (state_q == IDLE && in_valid) begin
         tx_d  = in_data;
         sh_d  = in_data;
         cnt_d = '0;
      end else if (active) begin
         cnt_d = (abort || last) ? '0 : cnt_q + CW'(1);
         sh_d  = {sh_q[WIDTH-2:0], 1'b0};
         if (cnt_q >= CAP_FIRST) rx_shift_d = {rx_shift_q[WIDTH-2:0], sio_dout};
      end else if (state_q == DONE) begin
         rx_hold_d = rx_shift_q;
         mm_hold_d = (rx_shift_q != tx_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         tx_q       <= '0;
         sh_q       <= '0;
         rx_shift_q <= '0;
         rx_hold_q  <= '0;
         mm_hold_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         sh_q       <= sh_d;
         rx_shift_q <= rx_shift_d;
         rx_hold_q  <= rx_hold_d;
         mm_hold_q  <= mm_hold_d;
      end
   end

   // In DONE the result comes straight from the capture register; elsewhere the held copy.
   always_comb begin
      in_ready = (state_q == IDLE);
      busy     = active;
      sio_en   = active;
      sio_din  = (state_q == SHIFT) && sh_q[WIDTH-1];
      rx_valid = (state_q == DONE);
      rx_data  = (state_q == DONE) ? rx_shift_q : rx_hold_q;
      mismatch = (state_q == DONE) ? (rx_shift_q != tx_q) : mm_hold_q;
   end

endmodule
